gpio_irq_ctrl: RTL and testbench

GPIO_IRQ_CTRL -- requirements
Module: gpio_irq_ctrl

---
 rtl/gpio_irq_ctrl.sv | 71 +++++++
 tb/tb_gpio_irq_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/gpio_irq_ctrl.sv
// GPIO input conditioning and interrupt capture: per-pin 2-flop synchronizer,
// glitch filter, edge detection into sticky ISR flags, and a registered IRQ.
module gpio_irq_ctrl #(
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] gpio_in,
  input  logic [31:0] ier,
  input  logic [31:0] rier,
  input  logic [31:0] fier,
  input  logic [31:0] isr_clr,
  output logic [31:0] idr,
  output logic [31:0] isr,
  output logic        irq
);

  localparam int unsigned N_PINS = 32;
  localparam int unsigned CNT_W  = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic [N_PINS-1:0]            s1;
  logic [N_PINS-1:0]            s2;
  logic [N_PINS-1:0][CNT_W-1:0] cnt;
  logic [N_PINS-1:0][CNT_W-1:0] cnt_nxt;
  logic [N_PINS-1:0]            idr_nxt;
  logic [N_PINS-1:0]            rise;
  logic [N_PINS-1:0]            fall;
  logic [N_PINS-1:0]            isr_nxt;

  // Filter: a pin must differ from idr for FILTER_LEN consecutive edges before it is accepted.
  always_comb begin
    idr_nxt = idr;
    cnt_nxt = '0;
    for (int i = 0; i < int'(N_PINS); i++) begin
      if (s2[i] != idr[i]) begin
        if (cnt[i] >= CNT_LAST) begin
          idr_nxt[i] = s2[i];
        end else begin
          cnt_nxt[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // A set event in the same cycle as a clear keeps the flag set.
  always_comb begin
    rise    = idr_nxt & ~idr;
    fall    = ~idr_nxt & idr;
    isr_nxt = (rise & rier) | (fall & fier) | (isr & ~isr_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1  <= '0;
      s2  <= '0;
      cnt <= '0;
      idr <= '0;
      isr <= '0;
      irq <= 1'b0;
    end else begin
      s1  <= gpio_in;
      s2  <= s1;
      cnt <= cnt_nxt;
      idr <= idr_nxt;
      isr <= isr_nxt;
      irq <= |(isr & ier);
    end
  end

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Directed bench for gpio_irq_ctrl: filter latency, glitch rejection, edge
// capture, clear/set priority, IRQ gating and reset behaviour.
module tb_gpio_irq_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] gpio_in;
  logic [31:0] ier;
  logic [31:0] rier;
  logic [31:0] fier;
  logic [31:0] isr_clr;
  logic [31:0] idr;
  logic [31:0] isr;
  logic        irq;

  int n_checks;
  int n_fail;

  gpio_irq_ctrl #(.FILTER_LEN(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .gpio_in (gpio_in),
    .ier     (ier),
    .rier    (rier),
    .fier    (fier),
    .isr_clr (isr_clr),
    .idr     (idr),
    .isr     (isr),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    gpio_in  = '0;
    ier      = '0;
    rier     = '0;
    fier     = '0;
    isr_clr  = '0;

    // Reset values are visible before any clock edge.
    #1;
    check("rst_idr", idr, 32'h0);
    check("rst_isr", isr, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    step(2);
    rst_n = 1'b1;

    // Rising edge on pin 3: idr/isr after E6, irq after E7.
    rier    = 32'h8;
    ier     = 32'h8;
    gpio_in = 32'h8;
    step(5);
    check("lat_e5_idr", idr, 32'h0);
    step(1);
    check("lat_e6_idr", idr, 32'h8);
    check("lat_e6_isr", isr, 32'h8);
    check("lat_e6_irq", {31'b0, irq}, 32'h0);
    step(1);
    check("lat_e7_irq", {31'b0, irq}, 32'h1);

    // W1C clear: isr drops next edge, irq one edge later.
    isr_clr = 32'h8;
    step(1);
    isr_clr = '0;
    check("clr_isr", isr, 32'h0);
    check("clr_irq_lag", {31'b0, irq}, 32'h1);
    step(1);
    check("clr_irq", {31'b0, irq}, 32'h0);

    // Three-cycle glitch on pin 5 is rejected.
    rier    = 32'h28;
    ier     = 32'h28;
    gpio_in = 32'h28;
    step(3);
    gpio_in = 32'h8;
    step(8);
    check("glitch_idr", idr, 32'h8);
    check("glitch_isr", isr, 32'h0);
    check("glitch_irq", {31'b0, irq}, 32'h0);

    // Four-cycle pulse on pin 5 is just long enough to be accepted.
    gpio_in = 32'h28;
    step(4);
    gpio_in = 32'h8;
    step(1);
    check("pulse4_e5_idr", idr, 32'h8);
    step(1);
    check("pulse4_e6_idr", idr, 32'h28);
    check("pulse4_e6_isr", isr, 32'h20);
    step(1);
    check("pulse4_e7_irq", {31'b0, irq}, 32'h1);
    step(3);
    check("pulse4_fall_idr", idr, 32'h8);
    check("pulse4_fall_noisr", isr, 32'h20);
    isr_clr = 32'h20;
    step(1);
    isr_clr = '0;
    check("pulse4_clr_isr", isr, 32'h0);
    step(1);
    check("pulse4_clr_irq", {31'b0, irq}, 32'h0);

    // Pin 2: rise not recorded (rier off), falling accept beats a same-edge clear.
    fier    = 32'h4;
    gpio_in = 32'h0C;
    step(6);
    check("p2_rise_idr", idr, 32'h0C);
    check("p2_rise_isr", isr, 32'h0);
    gpio_in = 32'h08;
    step(5);
    check("p2_fall_e5_idr", idr, 32'h0C);
    isr_clr = 32'h4;
    step(1);
    isr_clr = '0;
    check("p2_fall_idr", idr, 32'h08);
    check("p2_setwins_isr", isr, 32'h4);
    step(1);
    check("p2_ier_gate_irq", {31'b0, irq}, 32'h0);
    isr_clr = 32'h4;
    step(1);
    isr_clr = '0;
    check("p2_clr_isr", isr, 32'h0);

    // All pins toggle together with irq masked, then unmask pin 0.
    ier     = '0;
    rier    = 32'hFFFF_FFFF;
    fier    = 32'hFFFF_FFFF;
    gpio_in = 32'hFFFF_FFF7;
    step(6);
    check("all_idr", idr, 32'hFFFF_FFF7);
    check("all_isr", isr, 32'hFFFF_FFFF);
    check("all_irq_masked", {31'b0, irq}, 32'h0);
    step(1);
    check("all_irq_masked2", {31'b0, irq}, 32'h0);
    ier = 32'h1;
    step(1);
    check("all_irq_unmask", {31'b0, irq}, 32'h1);
    rier = '0;
    fier = '0;
    step(1);
    check("all_isr_hold", isr, 32'hFFFF_FFFF);
    isr_clr = 32'hFFFF_FFFF;
    ier     = '0;
    step(1);
    isr_clr = '0;
    check("all_clr_isr", isr, 32'h0);

    // Reset mid-count (cnt=2) aborts the falling transition without an event.
    fier    = 32'hFFFF_FFFF;
    gpio_in = 32'h0;
    step(4);
    rst_n = 1'b0;
    #1;
    check("midrst_idr", idr, 32'h0);
    check("midrst_isr", isr, 32'h0);
    check("midrst_irq", {31'b0, irq}, 32'h0);
    step(1);
    rst_n = 1'b1;
    step(8);
    check("midrst_post_idr", idr, 32'h0);
    check("midrst_post_isr", isr, 32'h0);

    // Pin held high through reset release with rier=0: idr follows, no isr.
    fier    = '0;
    rier    = '0;
    ier     = 32'h1;
    gpio_in = 32'h1;
    rst_n   = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(6);
    check("rel_norier_idr", idr, 32'h1);
    check("rel_norier_isr", isr, 32'h0);
    check("rel_norier_irq", {31'b0, irq}, 32'h0);

    // Same with rier=1: the post-reset rising accept is recorded.
    rst_n = 1'b0;
    rier  = 32'h1;
    step(1);
    rst_n = 1'b1;
    step(5);
    check("rel_rier_e5_idr", idr, 32'h0);
    step(1);
    check("rel_rier_idr", idr, 32'h1);
    check("rel_rier_isr", isr, 32'h1);
    step(1);
    check("rel_rier_irq", {31'b0, irq}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
